// File: rtl/wavelet_pkg.sv
// Shared definitions for the wavelet filter-bank sequencer: state encodings
// and the default geometry of the delay line and filter bank.
package wavelet_pkg;

  localparam int DEF_BITS_PER_ELEM = 8;
  localparam int DEF_NUM_ELEM      = 7;
  localparam int DEF_NUM_FILTERS   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tap_shift_reg.sv
// Sample delay line feeding the filter taps; element 0 holds the newest sample
// and the contents only move on an accepted sample.
module tap_shift_reg
  import wavelet_pkg::*;
#(
  parameter int BITS_PER_ELEM = DEF_BITS_PER_ELEM,
  parameter int NUM_ELEM      = DEF_NUM_ELEM
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              shift_en,
  input  logic [BITS_PER_ELEM-1:0]          din,
  output logic [NUM_ELEM*BITS_PER_ELEM-1:0] taps
);

  logic [BITS_PER_ELEM-1:0] elem_r [NUM_ELEM];

  // Delay-line register: clear on reset, shift one element per accepted sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ELEM; i++) begin
        elem_r[i] <= {BITS_PER_ELEM{1'b0}};
      end
    end else if (shift_en) begin
      elem_r[0] <= din;
      for (int i = 1; i < NUM_ELEM; i++) begin
        elem_r[i] <= elem_r[i-1];
      end
    end
  end

  for (genvar g = 0; g < NUM_ELEM; g++) begin : g_pack
    assign taps[g*BITS_PER_ELEM +: BITS_PER_ELEM] = elem_r[g];
  end

endmodule

// File: rtl/wavelet_sequencer.sv
// Captures samples into the tap delay line and strobes each filter of the bank
// in turn, then pulses done; samples arriving mid-sequence are dropped and flagged.
module wavelet_sequencer
  import wavelet_pkg::*;
#(
  parameter int BITS_PER_ELEM = DEF_BITS_PER_ELEM,
  parameter int NUM_ELEM      = DEF_NUM_ELEM,
  parameter int NUM_FILTERS   = DEF_NUM_FILTERS
) (
  input  logic                                                        clk,
  input  logic                                                        reset,
  input  logic [BITS_PER_ELEM-1:0]                                    i_sample,
  input  logic                                                        i_sample_valid,
  input  logic                                                        i_enable,
  input  logic                                                        i_clear_overrun,
  output logic [NUM_ELEM*BITS_PER_ELEM-1:0]                           o_taps,
  output logic [NUM_FILTERS-1:0]                                      o_start_calc,
  output logic [((NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1)-1:0]    o_filter_idx,
  output logic                                                        o_busy,
  output logic                                                        o_done,
  output logic                                                        o_overrun
);

  localparam int                     IDX_W      = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam logic [IDX_W-1:0]       LAST_IDX   = IDX_W'(NUM_FILTERS - 1);
  localparam logic [NUM_FILTERS-1:0] STROBE_LSB = NUM_FILTERS'(1);

  state_t                   state_r, state_next_s;
  logic [IDX_W-1:0]         idx_r, idx_next_s;
  logic [NUM_FILTERS-1:0]   start_calc_r, start_calc_next_s;
  logic                     busy_r, done_r, overrun_r, overrun_next_s;
  logic                     accept_s, drop_s;

  tap_shift_reg #(
    .BITS_PER_ELEM (BITS_PER_ELEM),
    .NUM_ELEM      (NUM_ELEM)
  ) u_taps (
    .clk      (clk),
    .reset    (reset),
    .shift_en (accept_s),
    .din      (i_sample),
    .taps     (o_taps)
  );

  // Next-state, index and flag logic; outputs are precomputed so they leave registers.
  always_comb begin
    accept_s          = (state_r == IDLE) && i_sample_valid && i_enable;
    drop_s            = (state_r != IDLE) && i_sample_valid;
    state_next_s      = state_r;
    idx_next_s        = idx_r;
    overrun_next_s    = overrun_r;
    start_calc_next_s = {NUM_FILTERS{1'b0}};

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = CALC;
          idx_next_s   = {IDX_W{1'b0}};
        end else begin
          state_next_s = IDLE;
          idx_next_s   = idx_r;
        end
      end
      CALC: begin
        if (idx_r == LAST_IDX) begin
          state_next_s = DONE;
          idx_next_s   = {IDX_W{1'b0}};
        end else begin
          state_next_s = CALC;
          idx_next_s   = idx_r + IDX_W'(1);
        end
      end
      DONE: begin
        state_next_s = IDLE;
        idx_next_s   = {IDX_W{1'b0}};
      end
      default: begin
        state_next_s = IDLE;
        idx_next_s   = {IDX_W{1'b0}};
      end
    endcase

    // A drop in the same cycle as a clear request keeps the flag set.
    if (drop_s) begin
      overrun_next_s = 1'b1;
    end else if (i_clear_overrun) begin
      overrun_next_s = 1'b0;
    end else begin
      overrun_next_s = overrun_r;
    end

    if (state_next_s == CALC) begin
      start_calc_next_s = STROBE_LSB << idx_next_s;
    end else begin
      start_calc_next_s = {NUM_FILTERS{1'b0}};
    end
  end

  // State, index and registered output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      idx_r        <= {IDX_W{1'b0}};
      start_calc_r <= {NUM_FILTERS{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      idx_r        <= idx_next_s;
      start_calc_r <= start_calc_next_s;
      busy_r       <= (state_next_s != IDLE);
      done_r       <= (state_next_s == DONE);
      overrun_r    <= overrun_next_s;
    end
  end

  assign o_start_calc = start_calc_r;
  assign o_filter_idx = idx_r;
  assign o_busy       = busy_r;
  assign o_done       = done_r;
  assign o_overrun    = overrun_r;

endmodule

// File: tb/tb_wavelet_sequencer.sv
// Directed self-checking bench for wavelet_sequencer with default geometry
// (8-bit elements, 7 taps, 4 filters).
module tb_wavelet_sequencer;

  localparam int W = 8;
  localparam int N = 7;
  localparam int F = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [W-1:0]   i_sample = 8'h00;
  logic           i_sample_valid = 1'b0;
  logic           i_enable = 1'b1;
  logic           i_clear_overrun = 1'b0;
  logic [N*W-1:0] o_taps;
  logic [F-1:0]   o_start_calc;
  logic [1:0]     o_filter_idx;
  logic           o_busy;
  logic           o_done;
  logic           o_overrun;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  wavelet_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .i_sample        (i_sample),
    .i_sample_valid  (i_sample_valid),
    .i_enable        (i_enable),
    .i_clear_overrun (i_clear_overrun),
    .o_taps          (o_taps),
    .o_start_calc    (o_start_calc),
    .o_filter_idx    (o_filter_idx),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_overrun       (o_overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Accept one sample, then idle until the cycle after its done pulse.
  task automatic send_sample(input logic [W-1:0] s);
    i_sample       = s;
    i_sample_valid = 1'b1;
    i_enable       = 1'b1;
    tick();
    i_sample_valid = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tests_run++;
    if (o_taps !== 56'h0) begin
      tests_failed++; $display("FAIL reset_taps got %h want %h", o_taps, 56'h0);
    end
    tests_run++;
    if ({o_start_calc, o_filter_idx, o_busy, o_done, o_overrun} !== 9'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl got start=%b idx=%0d busy=%b done=%b ovr=%b want all zero",
               o_start_calc, o_filter_idx, o_busy, o_done, o_overrun);
    end
  endtask

  task automatic test_single();
    logic [F-1:0] exp_start;
    pulse_reset();
    i_sample = 8'h05; i_sample_valid = 1'b1; i_enable = 1'b1;
    tick();
    i_sample_valid = 1'b0;
    tests_run++;
    if (o_taps !== 56'h05) begin
      tests_failed++; $display("FAIL single_taps got %h want %h", o_taps, 56'h05);
    end
    for (int k = 0; k < F; k++) begin
      if (k > 0) tick();
      exp_start = 4'b0001 << k;
      tests_run++;
      if (o_start_calc !== exp_start || o_filter_idx !== 2'(k) || o_busy !== 1'b1 || o_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL single_strobe%0d got start=%b idx=%0d busy=%b done=%b want start=%b idx=%0d busy=1 done=0",
                 k, o_start_calc, o_filter_idx, o_busy, o_done, exp_start, k);
      end
    end
    tick();
    tests_run++;
    if (o_done !== 1'b1 || o_start_calc !== 4'b0000 || o_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_done got done=%b start=%b busy=%b want done=1 start=0000 busy=1",
               o_done, o_start_calc, o_busy);
    end
    tick();
    tests_run++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      tests_failed++; $display("FAIL single_idle got done=%b busy=%b want done=0 busy=0", o_done, o_busy);
    end
  endtask

  task automatic test_fill();
    pulse_reset();
    for (int i = 1; i <= 7; i++) send_sample(8'(i));
    tests_run++;
    if (o_taps !== 56'h01020304050607) begin
      tests_failed++; $display("FAIL fill_seven got %h want %h", o_taps, 56'h01020304050607);
    end
    send_sample(8'h80);
    tests_run++;
    if (o_taps !== 56'h02030405060780 || o_overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_eighth got taps=%h ovr=%b want taps=%h ovr=0", o_taps, o_overrun, 56'h02030405060780);
    end
  endtask

  task automatic test_overrun();
    pulse_reset();
    i_sample = 8'h11; i_sample_valid = 1'b1; i_enable = 1'b1;
    tick();                                  // cycle t+1
    i_sample_valid = 1'b0;
    tick();                                  // cycle t+2
    i_sample = 8'h22; i_sample_valid = 1'b1;
    tick();                                  // cycle t+3
    i_sample_valid = 1'b0;
    tests_run++;
    if (o_overrun !== 1'b1 || o_taps !== 56'h11) begin
      tests_failed++;
      $display("FAIL ovr_calc_drop got ovr=%b taps=%h want ovr=1 taps=%h", o_overrun, o_taps, 56'h11);
    end
    i_clear_overrun = 1'b1;
    tick();                                  // cycle t+4
    i_clear_overrun = 1'b0;
    tests_run++;
    if (o_overrun !== 1'b0) begin
      tests_failed++; $display("FAIL ovr_clear got %b want 0", o_overrun);
    end
    tick();                                  // cycle t+5, DONE
    tests_run++;
    if (o_done !== 1'b1) begin
      tests_failed++; $display("FAIL ovr_done got %b want 1", o_done);
    end
    i_sample = 8'h55; i_sample_valid = 1'b1;
    tick();                                  // cycle t+6, IDLE
    i_sample_valid = 1'b0;
    tests_run++;
    if (o_overrun !== 1'b1 || o_taps !== 56'h11 || o_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovr_done_drop got ovr=%b taps=%h busy=%b want ovr=1 taps=%h busy=0",
               o_overrun, o_taps, o_busy, 56'h11);
    end
    i_sample = 8'h44; i_sample_valid = 1'b1;
    tick();
    i_sample = 8'h99; i_clear_overrun = 1'b1;
    tick();
    i_sample_valid = 1'b0; i_clear_overrun = 1'b0;
    tests_run++;
    if (o_overrun !== 1'b1 || o_taps !== 56'h1144) begin
      tests_failed++;
      $display("FAIL ovr_set_wins got ovr=%b taps=%h want ovr=1 taps=%h", o_overrun, o_taps, 56'h1144);
    end
    repeat (4) tick();
    i_clear_overrun = 1'b1;
    tick();
    i_clear_overrun = 1'b0;
  endtask

  task automatic test_enable();
    pulse_reset();
    i_enable = 1'b0; i_sample = 8'h33; i_sample_valid = 1'b1;
    tick();
    i_sample_valid = 1'b0;
    tests_run++;
    if (o_busy !== 1'b0 || o_start_calc !== 4'b0000 || o_overrun !== 1'b0 || o_taps !== 56'h0) begin
      tests_failed++;
      $display("FAIL enable_off got busy=%b start=%b ovr=%b taps=%h want busy=0 start=0000 ovr=0 taps=0",
               o_busy, o_start_calc, o_overrun, o_taps);
    end
    i_enable = 1'b1; i_sample = 8'h3C; i_sample_valid = 1'b1;
    tick();
    i_sample_valid = 1'b0; i_enable = 1'b0;
    repeat (4) tick();
    tests_run++;
    if (o_done !== 1'b1 || o_taps !== 56'h3C) begin
      tests_failed++;
      $display("FAIL enable_drop_mid got done=%b taps=%h want done=1 taps=%h", o_done, o_taps, 56'h3C);
    end
    i_enable = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    logic seen;
    pulse_reset();
    i_sample = 8'h66; i_sample_valid = 1'b1;
    tick();
    i_sample_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if (o_taps !== 56'h0 || o_start_calc !== 4'b0000 || o_busy !== 1'b0 || o_filter_idx !== 2'd0) begin
      tests_failed++;
      $display("FAIL rstmid_state got taps=%h start=%b busy=%b idx=%0d want all zero",
               o_taps, o_start_calc, o_busy, o_filter_idx);
    end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (o_done !== 1'b0 || o_start_calc !== 4'b0000) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_quiet got activity=%b want 0", seen);
    end
    i_sample = 8'h77; i_sample_valid = 1'b1;
    tick();
    i_sample_valid = 1'b0;
    tests_run++;
    if (o_start_calc !== 4'b0001 || o_filter_idx !== 2'd0 || o_taps !== 56'h77) begin
      tests_failed++;
      $display("FAIL rstmid_restart got start=%b idx=%0d taps=%h want start=0001 idx=0 taps=%h",
               o_start_calc, o_filter_idx, o_taps, 56'h77);
    end
    repeat (5) tick();
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    i_sample = 8'hA1; i_sample_valid = 1'b1;
    tick();
    i_sample_valid = 1'b0;
    repeat (4) tick();
    tests_run++;
    if (o_done !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_done got %b want 1", o_done);
    end
    tick();
    tests_run++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_idle got busy=%b done=%b want 0 0", o_busy, o_done);
    end
    i_sample = 8'hA2; i_sample_valid = 1'b1;
    tick();
    i_sample_valid = 1'b0;
    tests_run++;
    if (o_start_calc !== 4'b0001 || o_overrun !== 1'b0 || o_taps !== 56'hA1A2) begin
      tests_failed++;
      $display("FAIL b2b_accept got start=%b ovr=%b taps=%h want start=0001 ovr=0 taps=%h",
               o_start_calc, o_overrun, o_taps, 56'hA1A2);
    end
    repeat (5) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_overrun();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/wavelet_sequencer.md
WAVELET_SEQUENCER -- requirements
Module: wavelet_sequencer

Interface
REQ-001 Parameter BITS_PER_ELEM, default 8: width of one sample and of one tap element.
REQ-002 Parameter NUM_ELEM, default 7: number of tap elements in the delay line.
REQ-003 Parameter NUM_FILTERS, default 4: number of filter-bank instances sequenced.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 i_sample  input  BITS_PER_ELEM  signed input sample.
REQ-007 i_sample_valid  input  1  single-cycle strobe qualifying i_sample.
REQ-008 i_enable  input  1  gates acceptance of new samples.
REQ-009 i_clear_overrun  input  1  clears the sticky overrun flag.
REQ-010 o_taps  output  NUM_ELEM*BITS_PER_ELEM  delay-line contents; element 0 at bits [BITS_PER_ELEM-1:0] is the newest sample.
REQ-011 o_start_calc  output  NUM_FILTERS  one-hot calculation strobe, bit k drives the start input of filter k.
REQ-012 o_filter_idx  output  clog2(NUM_FILTERS), minimum 1  index of the filter currently strobed.
REQ-013 o_busy  output  1  high whenever the state is not IDLE.
REQ-014 o_done  output  1  single-cycle pulse; all filter outputs are valid for the newest sample.
REQ-015 o_overrun  output  1  sticky flag; a sample was dropped.

Function
REQ-016 The state machine SHALL have three states: IDLE, CALC and DONE.
REQ-017 IDLE->CALC SHALL occur when i_sample_valid=1 and i_enable=1; in the same edge the delay line SHALL shift (element n takes element n-1, element 0 takes i_sample, element NUM_ELEM-1 is discarded) and the index SHALL be set to 0.
REQ-018 In CALC, o_start_calc SHALL equal 1<<idx and the index SHALL increment by 1 per cycle.
REQ-019 CALC->DONE SHALL occur when idx=NUM_FILTERS-1; the index SHALL then wrap to 0.
REQ-020 DONE SHALL assert o_done for exactly one cycle and then return to IDLE unconditionally.
REQ-021 Latency: a sample accepted at edge t SHALL give o_start_calc bit k high in cycle t+1+k and o_done high in cycle t+1+NUM_FILTERS.
REQ-022 o_start_calc SHALL be all-zero outside CALC; it SHALL never have more than one bit set.
REQ-023 o_taps SHALL be stable from the accept edge until the next accept, so that every filter sees identical taps.
REQ-024 A sample with i_sample_valid=1 while in CALC or DONE SHALL be dropped and SHALL set o_overrun; the delay line SHALL not change.
REQ-025 A sample with i_sample_valid=1 in IDLE while i_enable=0 SHALL be ignored silently; o_overrun SHALL not change.
REQ-026 o_overrun SHALL clear on i_clear_overrun=1; on a simultaneous set and clear, set SHALL win.
REQ-027 Deasserting i_enable mid-sequence SHALL not abort the sequence; it completes through DONE.

Reset
REQ-028 With reset=1 at an edge: state SHALL become IDLE, idx 0, o_taps all zero, o_start_calc 0, o_busy 0, o_done 0, o_overrun 0.
REQ-029 Reset SHALL override all other inputs, including mid-sequence; no further o_start_calc or o_done SHALL follow for the aborted sample.

Structure
REQ-030 A shared package wavelet_pkg SHALL hold the state encodings (IDLE=0, CALC=1, DONE=2) and the default BITS_PER_ELEM, NUM_ELEM and NUM_FILTERS values.
REQ-031 The delay line SHALL be a sub-module tap_shift_reg with ports clk, reset, shift_en, din and taps.
REQ-032 The FSM, the index counter and the overrun flag SHALL reside in wavelet_sequencer.

Verification
REQ-033 Reset, then i_sample=8'h05 with valid and enable -> o_taps[7:0]=05, other elements 0; o_start_calc = 0001, 0010, 0100, 1000 on cycles t+1..t+4; o_done in cycle t+5.
REQ-034 Seven accepted samples 1..7, spaced 6 cycles apart -> o_taps = {01,02,03,04,05,06,07} with 07 at element 0; an eighth sample 8'h80 shifts out 01 and places 80 at element 0.
REQ-035 Sample 8'h11 accepted, then valid with 8'h22 in cycle t+2 -> 22 dropped, o_taps unchanged, o_overrun=1 until i_clear_overrun; set and clear in the same cycle leaves o_overrun=1.
REQ-036 i_enable=0 with valid and 8'h33 in IDLE -> no state change, o_busy=0, o_overrun=0.
REQ-037 Reset asserted in cycle t+2 of a sequence -> o_taps=0, o_start_calc=0, no o_done; the next accepted sample restarts at index 0.
REQ-038 A new sample in the cycle immediately after o_done is accepted with no overrun; back-to-back sequences run every NUM_FILTERS+2 cycles.
